// File: rtl/pipelined_datapath.sv
// pipelined_datapath: small register-file + ALU datapath run by a four-state FSM.
//
//   IDLE --START--> READ --> EXEC --> DONE --> IDLE
//
//   IDLE : external writes (WE/WADDR/DIN) are honoured; START captures RA/RB/RD/WB_EN/MS.
//   READ : operands A=reg[RA], B=reg[RB] are latched.
//   EXEC : RESULT/FLAGS are registered and the optional writeback to reg[RD] happens.
//   DONE : the state returns to IDLE. VALID is registered on this edge, so it is high
//          for the single cycle after DONE. A START accepted at edge k therefore
//          shows VALID between edges k+3 and k+4, and the next START can be taken
//          at edge k+4.
//
// Ports:
//   CLK, RST            clock, async active-high reset (clears FSM, regfile, outputs)
//   WE, WADDR, DIN      external register-file write, ignored while BUSY
//   START, RA, RB, RD   operation request and register addresses
//   WB_EN, MS           writeback enable, ALU mode
//   RESULT, FLAGS       registered ALU result and {C, V, Z}
//   VALID, BUSY         result strobe, operation in flight
module pipelined_datapath #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [AW-1:0]     WADDR,
  input  logic [DATA_W-1:0] DIN,
  input  logic              START,
  input  logic [AW-1:0]     RA,
  input  logic [AW-1:0]     RB,
  input  logic [AW-1:0]     RD,
  input  logic              WB_EN,
  input  logic [2:0]        MS,
  output logic [DATA_W-1:0] RESULT,
  output logic [2:0]        FLAGS,
  output logic              VALID,
  output logic              BUSY
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, DONE} state_t;

  localparam int MSB = DATA_W - 1;

  state_t            state;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [AW-1:0]     ra_q, rb_q, rd_q;
  logic              wb_q;
  logic [2:0]        ms_q;
  logic [DATA_W-1:0] a_q, b_q;

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_v;

  assign BUSY = (state != IDLE);

  // ALU works on the latched operands, so its output is stable throughout EXEC.
  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = a_q - b_q;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ms_q)
      3'b000: begin
        alu_res = sum[MSB:0];
        alu_c   = sum[DATA_W];
        alu_v   = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      3'b001: begin
        alu_res = diff;
        alu_c   = (a_q < b_q);
        alu_v   = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
      end
      3'b010: alu_res = a_q & b_q;
      3'b011: alu_res = a_q | b_q;
      3'b100: alu_res = a_q ^ b_q;
      3'b101: {alu_c, alu_res} = {a_q, 1'b0};
      3'b110: {alu_res, alu_c} = {1'b0, a_q};
      default: alu_res = a_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      ra_q   <= '0;
      rb_q   <= '0;
      rd_q   <= '0;
      wb_q   <= 1'b0;
      ms_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      RESULT <= '0;
      FLAGS  <= '0;
      VALID  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      VALID <= 1'b0;
      case (state)
        IDLE: begin
          // A write on the START edge lands before READ samples the regfile.
          if (WE) regs[WADDR] <= DIN;
          if (START) begin
            ra_q  <= RA;
            rb_q  <= RB;
            rd_q  <= RD;
            wb_q  <= WB_EN;
            ms_q  <= MS;
            state <= READ;
          end
        end
        READ: begin
          a_q   <= regs[ra_q];
          b_q   <= regs[rb_q];
          state <= EXEC;
        end
        EXEC: begin
          RESULT <= alu_res;
          FLAGS  <= {alu_c, alu_v, (alu_res == '0)};
          if (wb_q) regs[rd_q] <= alu_res;
          state  <= DONE;
        end
        default: begin
          VALID <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipelined_datapath.sv
module tb_pipelined_datapath;

  logic        CLK, RST, WE, START, WB_EN, VALID, BUSY;
  logic [2:0]  WADDR, RA, RB, RD, MS, FLAGS;
  logic [15:0] DIN, RESULT;

  int checks = 0;
  int errors = 0;

  pipelined_datapath #(.DATA_W(16), .NUM_REGS(8)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .DIN(DIN),
    .START(START), .RA(RA), .RB(RB), .RD(RD), .WB_EN(WB_EN), .MS(MS),
    .RESULT(RESULT), .FLAGS(FLAGS), .VALID(VALID), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge CLK); WE = 1'b1; WADDR = a; DIN = d;
    @(negedge CLK); WE = 1'b0;
  endtask

  // Issue one op; sample VALID on the 6 negedges after the START edge.
  // vpos = index of first VALID sample (1 = just after edge k), 0 if none.
  task automatic run_op(input logic [2:0] ms, input logic [2:0] ra, input logic [2:0] rb,
                        input logic [2:0] rd, input logic wb,
                        output logic [15:0] res, output logic [2:0] fl,
                        output int vpos, output int vcnt);
    @(negedge CLK);
    START = 1'b1; MS = ms; RA = ra; RB = rb; RD = rd; WB_EN = wb;
    vpos = 0; vcnt = 0; res = '0; fl = '0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      START = 1'b0;
      if (VALID) begin
        vcnt++;
        if (vpos == 0) begin vpos = i; res = RESULT; fl = FLAGS; end
      end
    end
  endtask

  task automatic test_reset();
    logic [15:0] r; logic [2:0] f; int vp, vc;
    RST = 1'b1; WE = 0; START = 0; WADDR = 0; DIN = 0; RA = 0; RB = 0; RD = 0; WB_EN = 0; MS = 0;
    repeat (2) @(negedge CLK);
    checks++; if (RESULT !== 16'h0) begin errors++; $display("FAIL reset_result got %h want 0000", RESULT); end
    checks++; if (FLAGS !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", FLAGS); end
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", VALID); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", BUSY); end
    RST = 1'b0;
    run_op(3'b111, 3'd5, 3'd0, 3'd0, 1'b0, r, f, vp, vc);
    checks++; if (r !== 16'h0 || f !== 3'b001) begin errors++; $display("FAIL reset_reg5 got %h/%b want 0000/001", r, f); end
  endtask

  task automatic test_add_basic();
    logic [15:0] r; logic [2:0] f; int vp, vc;
    wr(3'd1, 16'h0005); wr(3'd2, 16'h0003);
    run_op(3'b000, 3'd1, 3'd2, 3'd3, 1'b1, r, f, vp, vc);
    checks++; if (vp !== 4 || vc !== 1) begin errors++; $display("FAIL add_valid_timing got pos %0d cnt %0d want pos 4 cnt 1", vp, vc); end
    checks++; if (r !== 16'h0008) begin errors++; $display("FAIL add_result got %h want 0008", r); end
    checks++; if (f !== 3'b000) begin errors++; $display("FAIL add_flags got %b want 000", f); end
    run_op(3'b111, 3'd3, 3'd0, 3'd0, 1'b0, r, f, vp, vc);
    checks++; if (r !== 16'h0008) begin errors++; $display("FAIL add_writeback r3 got %h want 0008", r); end
  endtask

  task automatic test_add_flags();
    logic [15:0] r; logic [2:0] f; int vp, vc;
    wr(3'd1, 16'h7FFF); wr(3'd2, 16'h0001);
    run_op(3'b000, 3'd1, 3'd2, 3'd0, 1'b0, r, f, vp, vc);
    checks++; if (r !== 16'h8000 || f !== 3'b010) begin errors++; $display("FAIL add_overflow got %h/%b want 8000/010", r, f); end
    wr(3'd1, 16'hFFFF);
    run_op(3'b000, 3'd1, 3'd2, 3'd0, 1'b0, r, f, vp, vc);
    checks++; if (r !== 16'h0000 || f !== 3'b101) begin errors++; $display("FAIL add_carry got %h/%b want 0000/101", r, f); end
  endtask

  task automatic test_sub_shift_logic();
    logic [15:0] r; logic [2:0] f; int vp, vc;
    wr(3'd1, 16'h0003); wr(3'd2, 16'h0005);
    run_op(3'b001, 3'd1, 3'd2, 3'd0, 1'b0, r, f, vp, vc);
    checks++; if (r !== 16'hFFFE || f !== 3'b100) begin errors++; $display("FAIL sub_borrow got %h/%b want fffe/100", r, f); end
    run_op(3'b001, 3'd2, 3'd1, 3'd0, 1'b0, r, f, vp, vc);
    checks++; if (r !== 16'h0002 || f !== 3'b000) begin errors++; $display("FAIL sub_plain got %h/%b want 0002/000", r, f); end
    wr(3'd1, 16'h8001);
    run_op(3'b101, 3'd1, 3'd0, 3'd0, 1'b0, r, f, vp, vc);
    checks++; if (r !== 16'h0002 || f !== 3'b100) begin errors++; $display("FAIL shl got %h/%b want 0002/100", r, f); end
    run_op(3'b110, 3'd1, 3'd0, 3'd0, 1'b0, r, f, vp, vc);
    checks++; if (r !== 16'h4000 || f !== 3'b100) begin errors++; $display("FAIL shr got %h/%b want 4000/100", r, f); end
    wr(3'd1, 16'hF0F0); wr(3'd2, 16'h0FF0);
    run_op(3'b010, 3'd1, 3'd2, 3'd0, 1'b0, r, f, vp, vc);
    checks++; if (r !== 16'h00F0 || f !== 3'b000) begin errors++; $display("FAIL and got %h/%b want 00f0/000", r, f); end
    run_op(3'b011, 3'd1, 3'd2, 3'd0, 1'b0, r, f, vp, vc);
    checks++; if (r !== 16'hFFF0) begin errors++; $display("FAIL or got %h want fff0", r); end
    run_op(3'b100, 3'd1, 3'd2, 3'd0, 1'b0, r, f, vp, vc);
    checks++; if (r !== 16'hFF00) begin errors++; $display("FAIL xor got %h want ff00", r); end
    wr(3'd1, 16'h0000);
    run_op(3'b111, 3'd1, 3'd0, 3'd0, 1'b0, r, f, vp, vc);
    checks++; if (r !== 16'h0000 || f !== 3'b001) begin errors++; $display("FAIL pass_zero got %h/%b want 0000/001", r, f); end
  endtask

  task automatic test_back_to_back_alias();
    logic [15:0] r; logic [2:0] f; int vp, vc;
    wr(3'd4, 16'h0021);
    @(negedge CLK); START = 1'b1; MS = 3'b000; RA = 3'd4; RB = 3'd4; RD = 3'd4; WB_EN = 1'b1;
    @(negedge CLK); START = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (VALID !== 1'b1 || RESULT !== 16'h0042) begin errors++; $display("FAIL alias_first got v%b %h want v1 0042", VALID, RESULT); end
    START = 1'b1;  // accepted at edge k+4
    @(negedge CLK); START = 1'b0;
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL b2b_accept busy got %b want 1", BUSY); end
    repeat (3) @(negedge CLK);
    checks++; if (VALID !== 1'b1 || RESULT !== 16'h0084) begin errors++; $display("FAIL b2b_second got v%b %h want v1 0084", VALID, RESULT); end
    run_op(3'b111, 3'd4, 3'd0, 3'd0, 1'b0, r, f, vp, vc);
    checks++; if (r !== 16'h0084) begin errors++; $display("FAIL alias_r4 got %h want 0084", r); end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] r; logic [2:0] f; int vp, vc, nv;
    wr(3'd5, 16'h1111);
    @(negedge CLK); START = 1'b1; MS = 3'b000; RA = 3'd5; RB = 3'd5; RD = 3'd6; WB_EN = 1'b1;
    @(negedge CLK);
    nv = 0;
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL busy_flag got %b want 1", BUSY); end
    RD = 3'd7; WE = 1'b1; WADDR = 3'd5; DIN = 16'hDEAD;  // START still high
    for (int i = 2; i <= 10; i++) begin
      @(negedge CLK);
      if (i == 3) begin START = 1'b0; WE = 1'b0; end
      if (VALID) nv++;
    end
    checks++; if (nv !== 1) begin errors++; $display("FAIL busy_one_valid got %0d want 1", nv); end
    checks++; if (RESULT !== 16'h2222) begin errors++; $display("FAIL busy_result got %h want 2222", RESULT); end
    run_op(3'b111, 3'd5, 3'd0, 3'd0, 1'b0, r, f, vp, vc);
    checks++; if (r !== 16'h1111) begin errors++; $display("FAIL busy_we_dropped r5 got %h want 1111", r); end
    run_op(3'b111, 3'd7, 3'd0, 3'd0, 1'b0, r, f, vp, vc);
    checks++; if (r !== 16'h0000) begin errors++; $display("FAIL busy_start_dropped r7 got %h want 0000", r); end
    run_op(3'b111, 3'd6, 3'd0, 3'd0, 1'b0, r, f, vp, vc);
    checks++; if (r !== 16'h2222) begin errors++; $display("FAIL busy_wb r6 got %h want 2222", r); end
  endtask

  task automatic test_reset_exec();
    logic [15:0] r; logic [2:0] f; int vp, vc, nv;
    wr(3'd1, 16'h0005); wr(3'd2, 16'h0003);
    @(negedge CLK); START = 1'b1; MS = 3'b000; RA = 3'd1; RB = 3'd2; RD = 3'd7; WB_EN = 1'b1;
    @(negedge CLK); START = 1'b0;   // READ
    @(negedge CLK);                 // EXEC
    RST = 1'b1;
    #1;
    checks++; if (RESULT !== 16'h0 || FLAGS !== 3'b000 || VALID !== 1'b0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL rst_async got %h/%b v%b b%b want 0000/000 v0 b0", RESULT, FLAGS, VALID, BUSY);
    end
    nv = 0;
    repeat (3) begin @(negedge CLK); if (VALID) nv++; end
    // First edge after release: write r2 and START a pass of r2 together.
    RST = 1'b0; WE = 1'b1; WADDR = 3'd2; DIN = 16'h0009;
    START = 1'b1; MS = 3'b111; RA = 3'd2; WB_EN = 1'b0;
    vp = 0; r = '0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      START = 1'b0; WE = 1'b0;
      if (VALID) begin if (vp == 0) begin vp = i; r = RESULT; end end
    end
    checks++; if (nv !== 0) begin errors++; $display("FAIL rst_no_valid got %0d want 0", nv); end
    checks++; if (vp !== 4 || r !== 16'h0009) begin errors++; $display("FAIL rst_first_edge got pos %0d %h want pos 4 0009", vp, r); end
    run_op(3'b111, 3'd7, 3'd0, 3'd0, 1'b0, r, f, vp, vc);
    checks++; if (r !== 16'h0000) begin errors++; $display("FAIL rst_no_wb r7 got %h want 0000", r); end
    run_op(3'b111, 3'd1, 3'd0, 3'd0, 1'b0, r, f, vp, vc);
    checks++; if (r !== 16'h0000) begin errors++; $display("FAIL rst_clear r1 got %h want 0000", r); end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_add_flags();
    test_sub_shift_logic();
    test_back_to_back_alias();
    test_busy_ignore();
    test_reset_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
